// File: rtl/mac_pkg.sv
// Shared types and widths for the 8-bit multiply-accumulate datapath.
package mac_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned ACC_W    = 20;

  typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port, no reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result buffer behind the MAC stage; drops results when full
// and keeps a sticky overflow flag plus a saturating drop counter.
module mac_result_fifo
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = ACC_W,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] f_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic [CNTW-1:0]  drop_count
);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNTW-1:0]  drop_count_q, drop_count_d;
  logic             push, pop, drop;
  logic [WIDTH-1:0] rdata;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr_q),
    .wdata (f_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Status decode from registered occupancy.
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign valid_out  = !empty;
  assign data_out   = empty ? '0 : rdata;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  // A write into a full FIFO is only accepted when the head leaves on the same edge.
  assign pop  = valid_out && ready_in;
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule
